sim_result_ctrl: RTL and testbench

Synthesizable sequencer for simulation pass/fail reporting on the tinyriscv core.
- Snoops the GPR write-back port for the x26/x27 signature and decides pass, fail or timeout.
- On a decision, streams a 31-entry register dump (x1..x31) over a valid/ready port for the testbench or a UART bridge.
- Sits beside tinyriscv_core in the SoC; re-arms on debug ndmreset.

---
 rtl/sim_ctrl_pkg.sv | 26 ++
 rtl/gpr_dump_seq.sv | 72 +++++++
 rtl/sim_result_ctrl.sv | 110 +++++++++++
 tb/tb_sim_result_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation result sequencer.
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          NUM_DUMP_REGS  = 31;
  localparam logic [4:0]  FIRST_DUMP_REG = 5'd1;
  localparam logic [4:0]  LAST_DUMP_REG  = FIRST_DUMP_REG + 5'(NUM_DUMP_REGS - 1);
  localparam logic [31:0] PASS_VALUE     = 32'h1;

  typedef struct packed {
    logic pass;
    logic fail;
    logic timeout;
  } verdict_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/gpr_dump_seq.sv
// Register-dump sequencer: reads x1..x31 one at a time and offers each
// as a valid/ready beat. Started by a one-cycle pulse, reports the last beat.
module gpr_dump_seq
  import sim_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ndmreset_i,
  input  logic        start_i,
  output logic        finish_o,
  output logic [4:0]  gpr_raddr_o,
  input  logic [31:0] gpr_rdata_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [4:0]  dump_idx_o,
  output logic [31:0] dump_data_o
);

  // RUN doubles as the idle phase here; DONE parks after the final beat.
  state_t      r_phase;
  logic [4:0]  r_idx;
  logic        r_valid;
  logic [4:0]  r_idx_out;
  logic [31:0] r_data;

  assign finish_o     = (r_phase == SEND) && dump_ready_i && (r_idx == LAST_DUMP_REG);
  assign gpr_raddr_o  = (r_phase == LOAD) ? r_idx : 5'd0;
  assign dump_valid_o = r_valid;
  assign dump_idx_o   = r_idx_out;
  assign dump_data_o  = r_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_phase   <= RUN;
      r_idx     <= FIRST_DUMP_REG;
      r_valid   <= 1'b0;
      r_idx_out <= 5'd0;
      r_data    <= 32'd0;
    end else if (ndmreset_i) begin
      r_phase   <= RUN;
      r_idx     <= FIRST_DUMP_REG;
      r_valid   <= 1'b0;
      r_idx_out <= 5'd0;
      r_data    <= 32'd0;
    end else begin
      case (r_phase)
        RUN: begin
          if (start_i) r_phase <= LOAD;
        end
        LOAD: begin
          r_data    <= gpr_rdata_i;
          r_idx_out <= r_idx;
          r_valid   <= 1'b1;
          r_phase   <= SEND;
        end
        SEND: begin
          if (dump_ready_i) begin
            r_valid <= 1'b0;
            if (r_idx == LAST_DUMP_REG) begin
              r_phase <= DONE;
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_phase <= LOAD;
            end
          end
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: rtl/sim_result_ctrl.sv
// Pass/fail/timeout detector for tinyriscv simulations; snoops GPR
// write-back and hands the register dump to gpr_dump_seq.
module sim_result_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  parameter logic [4:0]  DONE_REG       = 5'd26,
  parameter logic [4:0]  RESULT_REG     = 5'd27,
  parameter logic        DUMP_EN        = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ndmreset_i,
  input  logic        gpr_we_i,
  input  logic [4:0]  gpr_waddr_i,
  input  logic [31:0] gpr_wdata_i,
  output logic [4:0]  gpr_raddr_o,
  input  logic [31:0] gpr_rdata_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [4:0]  dump_idx_o,
  output logic [31:0] dump_data_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [31:0] cycle_cnt_o
);

  // Top only uses RUN, SEND (dump in flight inside gpr_dump_seq) and DONE.
  state_t      r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_shadow;
  verdict_t    r_verdict;
  logic        r_done;

  logic [31:0] w_cnt_next;
  logic        w_trigger;
  logic        w_timeout;
  logic        w_start;
  logic        w_finish;
  logic        w_is_pass;

  assign w_cnt_next = sat_inc(r_cnt);
  assign w_trigger  = gpr_we_i && (gpr_waddr_i == DONE_REG) && (gpr_wdata_i == 32'h1);
  assign w_timeout  = (TIMEOUT_CYCLES != 32'd0) && (w_cnt_next == TIMEOUT_CYCLES);
  assign w_is_pass  = (r_shadow == PASS_VALUE);
  assign w_start    = DUMP_EN && (r_state == RUN) && (w_trigger || w_timeout) && !ndmreset_i;

  assign done_o      = r_done;
  assign pass_o      = r_verdict.pass;
  assign fail_o      = r_verdict.fail;
  assign timeout_o   = r_verdict.timeout;
  assign cycle_cnt_o = r_cnt;

  gpr_dump_seq u_dump (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ndmreset_i   (ndmreset_i),
    .start_i      (w_start),
    .finish_o     (w_finish),
    .gpr_raddr_o  (gpr_raddr_o),
    .gpr_rdata_i  (gpr_rdata_i),
    .dump_valid_o (dump_valid_o),
    .dump_ready_i (dump_ready_i),
    .dump_idx_o   (dump_idx_o),
    .dump_data_o  (dump_data_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= RUN;
      r_cnt     <= 32'd0;
      r_shadow  <= 32'd0;
      r_verdict <= '0;
      r_done    <= 1'b0;
    end else if (ndmreset_i) begin
      r_state   <= RUN;
      r_cnt     <= 32'd0;
      r_shadow  <= 32'd0;
      r_verdict <= '0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_cnt <= w_cnt_next;
          if (gpr_we_i && (gpr_waddr_i == RESULT_REG)) r_shadow <= gpr_wdata_i;
          // Trigger beats a coincident timeout; the shadow used is the pre-edge value.
          if (w_trigger) begin
            r_verdict <= '{pass: w_is_pass, fail: ~w_is_pass, timeout: 1'b0};
          end else if (w_timeout) begin
            r_verdict <= '{pass: 1'b0, fail: 1'b0, timeout: 1'b1};
          end
          if (w_trigger || w_timeout) begin
            r_state <= DUMP_EN ? SEND : DONE;
            r_done  <= ~DUMP_EN;
          end
        end
        SEND: begin
          if (w_finish) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_result_ctrl.sv
// Randomised bench for sim_result_ctrl with a behavioural model of the
// verdict/dump sequence checked every cycle, plus literal spot checks.
module tb_sim_result_ctrl;

  localparam logic [31:0] T_A = 32'd100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ndm = 1'b0;
  logic        we = 1'b0;
  logic        we_b = 1'b0;
  logic        ready = 1'b0;
  logic [4:0]  waddr = 5'd0;
  logic [31:0] wdata = 32'd0;
  int          mode = 2;

  logic [4:0]  raddr_a, idx_a;
  logic [31:0] rdata_a, data_a, cnt_a;
  logic        valid_a, done_a, pass_a, fail_a, to_a;
  logic [4:0]  raddr_b, idx_b;
  logic [31:0] data_b, cnt_b;
  logic        valid_b, done_b, pass_b, fail_b, to_b;

  logic [31:0] gpr_mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if ((we || we_b) && waddr != 5'd0) gpr_mem[waddr] <= wdata;
  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : gpr_mem[raddr_a];

  sim_result_ctrl #(.TIMEOUT_CYCLES(T_A), .DUMP_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .ndmreset_i(ndm),
    .gpr_we_i(we), .gpr_waddr_i(waddr), .gpr_wdata_i(wdata),
    .gpr_raddr_o(raddr_a), .gpr_rdata_i(rdata_a),
    .dump_valid_o(valid_a), .dump_ready_i(ready),
    .dump_idx_o(idx_a), .dump_data_o(data_a),
    .done_o(done_a), .pass_o(pass_a), .fail_o(fail_a),
    .timeout_o(to_a), .cycle_cnt_o(cnt_a)
  );

  sim_result_ctrl #(.TIMEOUT_CYCLES(32'd0), .DUMP_EN(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .ndmreset_i(1'b0),
    .gpr_we_i(we_b), .gpr_waddr_i(waddr), .gpr_wdata_i(wdata),
    .gpr_raddr_o(raddr_b), .gpr_rdata_i(32'd0),
    .dump_valid_o(valid_b), .dump_ready_i(1'b1),
    .dump_idx_o(idx_b), .dump_data_o(data_b),
    .done_o(done_b), .pass_o(pass_b), .fail_o(fail_b),
    .timeout_o(to_b), .cycle_cnt_o(cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = running, 1 = dumping, 2 = finished.
  int          m_phase = 0;
  int          m_beat = 1;
  int          m_hs = 0;
  logic        m_sending = 1'b0;
  logic [31:0] m_cnt = 0, m_shadow = 0, m_data = 0, m_nxt = 0;
  logic [4:0]  m_idx = 0;
  logic        m_pass = 0, m_fail = 0, m_to = 0, m_trig = 0, m_tmo = 0;

  always @(posedge clk or posedge rst) begin
    if (rst || ndm) begin
      m_phase = 0; m_beat = 1; m_hs = 0; m_sending = 0;
      m_cnt = 0; m_shadow = 0; m_data = 0; m_idx = 0;
      m_pass = 0; m_fail = 0; m_to = 0;
    end else if (m_phase == 0) begin
      m_nxt  = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 32'd1;
      m_trig = we && waddr == 5'd26 && wdata == 32'd1;
      m_tmo  = (m_nxt == T_A);
      if (m_trig) begin
        m_pass = (m_shadow == 32'd1);
        m_fail = !m_pass;
      end else if (m_tmo) begin
        m_to = 1'b1;
      end
      if (we && waddr == 5'd27) m_shadow = wdata;
      m_cnt = m_nxt;
      if (m_trig || m_tmo) begin
        m_phase = 1; m_beat = 1; m_sending = 0;
      end
    end else if (m_phase == 1) begin
      if (!m_sending) begin
        m_sending = 1'b1;
        m_idx  = m_beat[4:0];
        m_data = gpr_mem[m_beat];
      end else if (ready) begin
        m_hs++;
        m_sending = 1'b0;
        if (m_beat == 31) m_phase = 2;
        else m_beat++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m_valid", valid_a, 32'(m_phase == 1 && m_sending));
    chk("m_idx",   idx_a,   m_idx);
    chk("m_data",  data_a,  m_data);
    chk("m_raddr", raddr_a, (m_phase == 1 && !m_sending) ? 32'(m_beat) : 32'd0);
    chk("m_done",  done_a,  32'(m_phase == 2));
    chk("m_pass",  pass_a,  m_pass);
    chk("m_fail",  fail_a,  m_fail);
    chk("m_tmo",   to_a,    m_to);
    chk("m_cnt",   cnt_a,   m_cnt);
  end

  task automatic step();
    @(negedge clk);
    we = 1'b0; we_b = 1'b0; ndm = 1'b0;
    case (mode)
      0:       ready = 1'($urandom_range(0, 1));
      1:       ready = 1'b0;
      default: ready = 1'b1;
    endcase
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step();
    we = 1'b1; waddr = a; wdata = d;
  endtask

  task automatic rearm();
    step();
    ndm = 1'b1;
    step();
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 500 && !done_a; i++) step();
    chk(name, done_a, 1);
  endtask

  task automatic wait_beat(input string name, input logic [4:0] want);
    for (int i = 0; i < 200 && !(valid_a && idx_a == want); i++) step();
    chk(name, {valid_a, idx_a}, {1'b1, want});
  endtask

  initial begin
    logic [31:0] v;
    repeat (3) step();
    chk("rst_done", done_a, 0);
    chk("rst_flags", {pass_a, fail_a, to_a}, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_idx", idx_a, 0);
    rst = 1'b0;

    for (int r = 1; r < 32; r++) begin
      v = $urandom;
      if (r == 26) v = v | 32'h2;
      wr(5'(r), v);
    end

    // Pass
    rearm();
    for (int k = 0; k < 4; k++) wr(5'($urandom_range(1, 25)), $urandom);
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    step();
    chk("pass_set", pass_a, 1);
    chk("pass_nofail", fail_a, 0);
    chk("pass_cnt", cnt_a, 7);
    mode = 0;
    wait_done("pass_done");
    chk("pass_beats", m_hs, 31);
    repeat (5) step();
    chk("pass_cnt_frozen", cnt_a, 7);
    chk("pass_hold", {done_a, valid_a}, 2'b10);

    // Fail, with an ignored non-1 write to x26
    rearm();
    wr(5'd27, 32'hDEAD);
    wr(5'd26, 32'd5);
    step(); step();
    chk("fail_ignored", {pass_a, fail_a, to_a}, 0);
    wr(5'd26, 32'd1);
    step();
    chk("fail_set", {pass_a, fail_a}, 2'b01);
    wait_done("fail_done");
    chk("fail_beats", m_hs, 31);

    // Backpressure on beat 3
    rearm();
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    mode = 2;
    wait_beat("bp_beat2", 5'd2);
    mode = 1;
    wait_beat("bp_beat3", 5'd3);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", valid_a, 1);
      chk("bp_idx", idx_a, 3);
      chk("bp_data", data_a, gpr_mem[3]);
    end
    mode = 2;
    wait_done("bp_done");
    chk("bp_beats", m_hs, 31);

    // ndmreset mid-SEND at idx 10 with ready high on the same edge
    rearm();
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    wait_beat("ndm_beat10", 5'd10);
    ndm = 1'b1;
    mode = 1;
    step();
    chk("ndm_valid", valid_a, 0);
    chk("ndm_flags", {pass_a, fail_a, to_a, done_a}, 0);
    chk("ndm_cnt", cnt_a, 0);
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    mode = 2;
    wait_beat("ndm_restart_idx1", 5'd1);
    mode = 0;
    wait_done("ndm_done");
    chk("ndm_pass", pass_a, 1);
    chk("ndm_beats", m_hs, 31);

    // Timeout after 100 RUN cycles
    rearm();
    for (int i = 0; i < 200 && !to_a; i++) step();
    chk("to_set", to_a, 1);
    chk("to_cnt", cnt_a, 100);
    chk("to_excl", {pass_a, fail_a}, 0);
    wait_done("to_done");

    // Trigger on the timeout edge wins
    rearm();
    wr(5'd27, 32'd1);
    for (int i = 0; i < 200 && cnt_a != 32'd99; i++) step();
    chk("sim_reach99", cnt_a, 99);
    we = 1'b1; waddr = 5'd26; wdata = 32'd1;
    step();
    chk("sim_pass", pass_a, 1);
    chk("sim_to", to_a, 0);
    chk("sim_cnt", cnt_a, 100);

    // Asynchronous reset while a beat is offered
    mode = 1;
    for (int i = 0; i < 20 && !valid_a; i++) step();
    chk("arst_pre_valid", valid_a, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", valid_a, 0);
    chk("arst_flags", {pass_a, fail_a, to_a, done_a}, 0);
    chk("arst_cnt", cnt_a, 0);
    chk("arst_idx", idx_a, 0);
    step(); step();
    rst = 1'b0;
    mode = 0;

    // Timeout disabled, no dump
    repeat (10050) step();
    chk("b_no_to", to_b, 0);
    chk("b_cnt", cnt_b, 10050);
    step();
    we_b = 1'b1; waddr = 5'd27; wdata = 32'd1;
    step();
    we_b = 1'b1; waddr = 5'd26; wdata = 32'd1;
    step();
    chk("b_pass", {pass_b, fail_b, to_b}, 3'b100);
    chk("b_done", done_b, 1);
    chk("b_valid", valid_b, 0);
    chk("b_cnt_final", cnt_b, 10053);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
